booth_mult_sched: RTL and testbench
===================================

// Module: booth_mult_sched
// PURPOSE
//  Shares one iterative radix-4 Booth multiplier among NREQ requesters.
//  - Round-robin arbiter grants one request at a time.
//  - Sequencer retires one Booth digit (2 multiplier bits) per clock.
//  - Returns a tagged 2*WIDTH-bit signed product on a valid/ready response port.
//  - Sits between DSP-side clients and the multiply resource; replaces per-client combinational multipliers.
// PARAMETERS
//  WIDTH  16  operand width in bits, two's complement; must be even and >= 4
//  NREQ   4   number of requesters; >= 2
//  IDW    2   localparam = clog2(NREQ); width of the response tag
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous, active-high reset
//  req_valid  in   NREQ         per-requester operand valid
//  req_x      in   NREQ*WIDTH   multiplicands; requester i in bits [i*WIDTH +: WIDTH]
//  req_y      in   NREQ*WIDTH   multipliers (Booth-recoded), same packing
//  req_ready  out  NREQ         one-hot grant; low for all requesters outside IDLE
//  rsp_valid  out  1            product valid
//  rsp_id     out  IDW          index of the requester that owns rsp_p
//  rsp_p      out  2*WIDTH      signed product x*y
//  rsp_ready  in   1            consumer accepts the response
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=NREQ-1 (requester 0 highest priority), rsp_valid=0, rsp_id=0, rsp_p=0, acc/cnt=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: req_ready = one-hot first asserted req_valid, searching from ptr+1 upward with wrap.
//    req_ready is combinational from req_valid and ptr; it is never asserted while req_valid is low.
//    Handshake edge (req_valid[i] & req_ready[i]): latch x_i, {y_i,1'b0}, id=i; ptr<=i; acc<=0; cnt<=0; go to RUN.
//  - RUN: each cycle, triplet {y[2k+1],y[2k],y[2k-1]} (k=cnt) selects a partial product.
//    Selection: 0 / +x / +2x / -2x / -x (000,111->0; 001,010->+x; 011->+2x; 100->-2x; 101,110->-x).
//    Partial product is sign-extended to WIDTH+2 bits, shifted left by 2k, and added into a 2*WIDTH-bit acc.
//    cnt increments each cycle; on cnt==N-1 (N=WIDTH/2) go to DONE with rsp_valid<=1 and rsp_p<=final sum.
//  - DONE: rsp_valid, rsp_id and rsp_p hold stable until rsp_ready is high.
//    On the edge where rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
//    No grant occurs in that same cycle.
//  Latency: rsp_valid rises N clock edges after the grant edge.
//  Throughput: minimum N+2 cycles per operation.
//  Arithmetic: result is the exact signed product; it always fits in 2*WIDTH bits.
//    Corner case: -2^(W-1) * -2^(W-1) = 2^(2W-2) (positive, fits).
//    -2x of min_int needs WIDTH+2 bits; this is the reason for the WIDTH+2 partial-product width.
//  Requester dropping req_valid before its grant: no effect; it is simply not granted.
//  Operands are sampled only at the grant edge. Later changes on req_x/req_y are ignored.
//  Reset asserted in any state: operation abandoned, no response emitted, all state returns to reset values.
//  rsp_ready high while rsp_valid is low: ignored.
// STRUCTURE
//  Package booth_pkg:
//  - state encoding (IDLE, RUN, DONE)
//  - Booth triplet codes and partial-product select enum (PP_ZERO, PP_PX, PP_P2X, PP_M2X, PP_MX)
//  - clog2 function
//  Sub-module booth_r4_step (combinational):
//  - inputs: x, triplet, k; output: shifted sign-extended partial product
//  - instantiated once and reused every RUN cycle
//  Top level holds the arbiter, FSM, counter, operand/tag registers and accumulator.
// TESTING (WIDTH=16, NREQ=4)
//  1. Single request: req_valid=0001, x=3, y=-5.
//     -> req_ready=0001 for 1 cycle; rsp_valid 8 edges later; rsp_p=32'hFFFF_FFF1; rsp_id=0.
//  2. Corner operands: x=y=16'h8000 -> 32'h4000_0000.
//     x=16'h8000, y=16'h7FFF -> 32'hC000_8000.
//     x=16'h7FFF, y=16'h7FFF -> 32'h3FFF_0001.
//     x=0, y=any -> 0.
//  3. All four req_valid held high, rsp_ready=1.
//     -> grants in order 0,1,2,3,0; rsp_id follows the same order; 10 cycles between grants.
//  4. rsp_ready low for 5 cycles in DONE.
//     -> rsp_valid/rsp_p/rsp_id stable; req_ready=0000; grant occurs 1 cycle after the response handshake.
//  5. rst pulsed during RUN at cnt=3.
//     -> rsp_valid stays 0; ptr resets; a next request from req 2 with req 0 also pending grants req 0 first.
//  6. 10k random (x,y,req_valid,rsp_ready) patterns: every rsp_p equals $signed(x)*$signed(y) of the granted pair.
//     Also check: no starvation; req_ready is always one-hot or zero.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the time-shared radix-4 Booth multiplier:
// FSM states, Booth triplet codes, partial-product selects and clog2.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    PP_ZERO = 3'd0,
    PP_PX   = 3'd1,
    PP_P2X  = 3'd2,
    PP_M2X  = 3'd3,
    PP_MX   = 3'd4
  } pp_sel_t;

  // Triplet is {y[2k+1], y[2k], y[2k-1]}
  localparam logic [2:0] TRIP_Z0  = 3'b000;
  localparam logic [2:0] TRIP_PX0 = 3'b001;
  localparam logic [2:0] TRIP_PX1 = 3'b010;
  localparam logic [2:0] TRIP_P2X = 3'b011;
  localparam logic [2:0] TRIP_M2X = 3'b100;
  localparam logic [2:0] TRIP_MX0 = 3'b101;
  localparam logic [2:0] TRIP_MX1 = 3'b110;
  localparam logic [2:0] TRIP_Z1  = 3'b111;

  function automatic pp_sel_t pp_decode(input logic [2:0] trip);
    case (trip)
      TRIP_PX0, TRIP_PX1: pp_decode = PP_PX;
      TRIP_P2X:           pp_decode = PP_P2X;
      TRIP_M2X:           pp_decode = PP_M2X;
      TRIP_MX0, TRIP_MX1: pp_decode = PP_MX;
      default:            pp_decode = PP_ZERO;
    endcase
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth digit: selects 0/+-x/+-2x from the triplet, sign-extends
// to 2*WIDTH bits and shifts it into position 2k.
module booth_r4_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [2:0]         triplet,
  input  logic [KW-1:0]      k,
  output logic [2*WIDTH-1:0] pp
);

  // WIDTH+2 bits so that -2 * min_int is representable
  logic [WIDTH+1:0]   x1;
  logic [WIDTH+1:0]   x2;
  logic [WIDTH+1:0]   mag;
  logic [2*WIDTH-1:0] ext;
  pp_sel_t            sel;

  assign x1  = {{2{x[WIDTH-1]}}, x};
  assign x2  = {x1[WIDTH:0], 1'b0};
  assign sel = pp_decode(triplet);

  always_comb begin
    mag = '0;
    case (sel)
      PP_PX:   mag = x1;
      PP_P2X:  mag = x2;
      PP_M2X:  mag = ~x2 + 1'b1;
      PP_MX:   mag = ~x1 + 1'b1;
      default: mag = '0;
    endcase
  end

  assign ext = {{(WIDTH-2){mag[WIDTH+1]}}, mag};
  assign pp  = ext << {k, 1'b0};

endmodule

// File: rtl/booth_mult_sched.sv
// Round-robin scheduler sharing one iterative radix-4 Booth multiplier
// among NREQ requesters; tagged product returned on a valid/ready port.
module booth_mult_sched
  import booth_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  localparam int IDW   = clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_p,
  input  logic                    rsp_ready
);

  localparam int N  = WIDTH / 2;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t             state_reg, state_next;
  logic [IDW-1:0]     ptr_reg, ptr_next;
  logic [IDW-1:0]     id_reg, id_next;
  logic [WIDTH-1:0]   x_reg, x_next;
  logic [WIDTH:0]     y_reg, y_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [2*WIDTH-1:0] rsp_p_reg, rsp_p_next;

  logic [WIDTH-1:0]   x_arr [NREQ];
  logic [WIDTH-1:0]   y_arr [NREQ];
  logic [NREQ-1:0]    grant;
  logic               found;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     cand;
  logic [2*WIDTH-1:0] pp_step;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign x_arr[gi] = req_x[gi*WIDTH +: WIDTH];
      assign y_arr[gi] = req_y[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // y_reg shifts right by one digit per cycle, so its low 3 bits are always the current triplet
  booth_r4_step #(
    .WIDTH (WIDTH),
    .KW    (CW)
  ) u_step (
    .x       (x_reg),
    .triplet (y_reg[2:0]),
    .k       (cnt_reg),
    .pp      (pp_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= IDW'(NREQ - 1);
      id_reg        <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_p_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      id_reg        <= id_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_p_reg     <= rsp_p_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    id_next        = id_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_p_next     = rsp_p_reg;
    grant          = '0;
    found          = 1'b0;
    gnt_idx        = '0;
    cand           = '0;

    // Search starts just after the last winner, so the winner drops to lowest priority
    if (state_reg == ST_IDLE) begin
      for (int j = 1; j <= NREQ; j++) begin
        cand = IDW'((int'(ptr_reg) + j) % NREQ);
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
      grant[gnt_idx] = found;
    end

    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          x_next     = x_arr[gnt_idx];
          y_next     = {y_arr[gnt_idx], 1'b0};
          id_next    = gnt_idx;
          ptr_next   = gnt_idx;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_next = acc_reg + pp_step;
        cnt_next = cnt_reg + 1'b1;
        y_next   = y_reg >> 2;
        if (cnt_reg == CNT_LAST) begin
          rsp_valid_next = 1'b1;
          rsp_p_next     = acc_reg + pp_step;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = id_reg;
  assign rsp_p     = rsp_p_reg;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Scoreboard bench for booth_mult_sched: directed corner cases plus a
// randomized phase checked against a round-robin / exact-product model.
module tb_booth_mult_sched;

  localparam int W = 16;
  localparam int R = 4;
  localparam int N = W / 2;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [R-1:0]  req_valid;
  logic [R*W-1:0] req_x;
  logic [R*W-1:0] req_y;
  logic [R-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_p;
  logic          rsp_ready;

  booth_mult_sched #(.WIDTH(W), .NREQ(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model / monitor state
  exp_t        exp_q[$];
  int          cyc = 0;
  int          rsp_count = 0;
  int          hs_cyc = 0;
  logic [31:0] last_p = '0;
  logic [1:0]  last_id = '0;
  logic [R-1:0] gnt_seen = '0;
  int          gnt_cyc_q[$];
  int          gnt_id_q[$];
  bit          busy = 1'b0;
  int          since = 0;
  int          last_gnt = R - 1;
  int          wait_gr[R];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] pr;
    pr = $signed(a) * $signed(b);
    return pr;
  endfunction

  // Monitor: samples 1 time unit before each rising edge
  initial begin
    for (int i = 0; i < R; i++) wait_gr[i] = 0;
    forever begin
      logic [R-1:0] exp_gnt;
      int           g;
      @(negedge clk);
      #4;
      cyc++;
      gnt_seen = '0;
      if (rst) begin
        chk("rst_rsp_valid", rsp_valid, 0);
        busy     = 1'b0;
        since    = 0;
        last_gnt = R - 1;
        exp_q.delete();
        for (int i = 0; i < R; i++) wait_gr[i] = 0;
      end else begin
        if (busy) since++;
        chk("ready_onehot0", $onehot0(req_ready), 1);
        exp_gnt = '0;
        g = -1;
        if (!busy) begin
          for (int j = 1; j <= R; j++) begin
            int c;
            c = (last_gnt + j) % R;
            if (g < 0 && req_valid[c]) g = c;
          end
          if (g >= 0) exp_gnt[g] = 1'b1;
        end
        chk("req_ready", req_ready, exp_gnt);
        chk("rsp_valid", rsp_valid, (busy && since >= N));
        if (rsp_valid && exp_q.size() > 0) begin
          chk("rsp_id", rsp_id, exp_q[0].id);
          chk("rsp_p", rsp_p, exp_q[0].p);
        end
        if (rsp_valid && rsp_ready && busy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          last_p  = rsp_p;
          last_id = rsp_id;
          rsp_count++;
          hs_cyc = cyc;
          busy   = 1'b0;
          $display("rsp #%0d id=%0d p=%08h cycle=%0d", rsp_count, rsp_id, rsp_p, cyc);
        end
        for (int i = 0; i < R; i++) if (!req_valid[i]) wait_gr[i] = 0;
        if (g >= 0) begin
          exp_t e;
          e.id = 2'(g);
          e.p  = ref_mul(req_x[g*W +: W], req_y[g*W +: W]);
          exp_q.push_back(e);
          chk("no_starvation", (wait_gr[g] <= R - 1), 1);
          for (int i = 0; i < R; i++) if (i != g && req_valid[i]) wait_gr[i]++;
          wait_gr[g] = 0;
          busy     = 1'b1;
          since    = -1;
          last_gnt = g;
          gnt_seen = exp_gnt;
          gnt_cyc_q.push_back(cyc);
          gnt_id_q.push_back(g);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gnt_seen[i] && n < 100);
    if (!gnt_seen[i]) begin
      errors++;
      $display("FAIL wait_gnt: no grant to req %0d within %0d cycles", i, n);
    end
  endtask

  task automatic wait_rsp(input int rc);
    int n;
    n = 0;
    while (rsp_count == rc && n < 100) begin
      tick();
      n++;
    end
    if (rsp_count == rc) begin
      errors++;
      $display("FAIL wait_rsp: no response within %0d cycles", n);
    end
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    tick();
    tick();
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) begin
      errors++;
      $display("FAIL drain: response never retired");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_op(input int i, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp_p, input string nm);
    int rc;
    rc = rsp_count;
    set_op(i, x, y);
    req_valid[i] = 1'b1;
    wait_gnt(i);
    req_valid[i] = 1'b0;
    wait_rsp(rc);
    chk({nm, "_p"}, last_p, exp_p);
    chk({nm, "_id"}, last_id, 2'(i));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_p", rsp_p, 0);
    chk("reset_req_ready", req_ready, 0);

    // single request and corner operands
    do_op(0, 16'd3, 16'hFFFB, 32'hFFFF_FFF1, "single");
    do_op(0, 16'h8000, 16'h8000, 32'h4000_0000, "min_min");
    do_op(0, 16'h8000, 16'h7FFF, 32'hC000_8000, "min_max");
    do_op(0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "max_max");
    do_op(0, 16'h0000, 16'hA5C3, 32'h0000_0000, "zero_x");

    // all four requesters held high from reset
    do_reset();
    gnt_cyc_q.delete();
    gnt_id_q.delete();
    for (int i = 0; i < R; i++) set_op(i, 16'(i * 1000 + 7), 16'(16'hF000 + i));
    req_valid = '1;
    begin
      int n;
      n = 0;
      while (gnt_id_q.size() < 5 && n < 200) begin
        tick();
        n++;
      end
    end
    req_valid = '0;
    chk("rr_grant_count", (gnt_id_q.size() >= 5), 1);
    if (gnt_id_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", gnt_id_q[i], i % R);
      for (int i = 1; i < 5; i++) chk("rr_spacing", gnt_cyc_q[i] - gnt_cyc_q[i-1], N + 2);
    end
    drain();

    // response back-pressure for 5 cycles
    rsp_ready = 1'b0;
    set_op(1, 16'h1234, 16'hFEDC);
    req_valid[1] = 1'b1;
    wait_gnt(1);
    req_valid[1] = 1'b0;
    set_op(1, 16'h5555, 16'h5555);
    set_op(2, 16'h0101, 16'h0202);
    req_valid[2] = 1'b1;
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin
        tick();
        n++;
      end
    end
    chk("stall_rsp_valid", rsp_valid, 1);
    repeat (5) tick();
    chk("stall_p_held", rsp_p, ref_mul(16'h1234, 16'hFEDC));
    chk("stall_id_held", rsp_id, 1);
    rsp_ready = 1'b1;
    wait_gnt(2);
    req_valid[2] = 1'b0;
    if (gnt_cyc_q.size() > 0) chk("stall_gnt_gap", gnt_cyc_q[$] - hs_cyc, 1);
    drain();

    // reset in the middle of RUN
    begin
      int rc;
      set_op(1, 16'h7777, 16'h3333);
      req_valid[1] = 1'b1;
      wait_gnt(1);
      req_valid[1] = 1'b0;
      rc = rsp_count;
      repeat (3) tick();
      rst = 1'b1;
      set_op(0, 16'h0011, 16'h0022);
      set_op(2, 16'h0033, 16'h0044);
      req_valid[0] = 1'b1;
      req_valid[2] = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_no_rsp", rsp_count, rc);
      begin
        int n;
        n = 0;
        do begin
          tick();
          n++;
        end while (gnt_seen == '0 && n < 20);
      end
      chk("rst_first_gnt", gnt_seen, 4'b0001);
      req_valid[0] = 1'b0;
      wait_gnt(2);
      req_valid[2] = 1'b0;
      drain();
    end

    // randomized traffic
    for (int t = 0; t < 10000; t++) begin
      tick();
      for (int i = 0; i < R; i++) begin
        if (req_valid[i] && gnt_seen[i]) begin
          if ($urandom_range(1) == 0) req_valid[i] = 1'b0;
          else set_op(i, 16'($urandom), 16'($urandom));
        end else if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            logic [15:0] xv, yv;
            xv = 16'($urandom);
            yv = 16'($urandom);
            case ($urandom_range(7))
              0: xv = 16'h8000;
              1: yv = 16'h8000;
              2: begin xv = 16'h7FFF; yv = 16'h8000; end
              3: xv = 16'h0000;
              default: ;
            endcase
            set_op(i, xv, yv);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
